mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 138 +++++++++++++
 tb/tb_mem_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Data-memory pipeline stage: byte/half/word loads and stores into a local RAM, then the MEM/WB register.
// Latency: load data and all MEM/WB fields appear 1 cycle after the instruction is presented; forward_ex_mem is combinational.
// Backpressure: stall holds MEM/WB and the captured read word and blocks the store; flush inserts a bubble; rst overrides both.
module mem_stage #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_data,
    input  logic [31:0] memory_data,
    input  logic [4:0]  rd_in,
    output logic [31:0] forward_ex_mem,
    output logic [31:0] mem_wb_alu_data,
    output logic [31:0] mem_wb_read_data,
    output logic [4:0]  mem_wb_rd,
    output logic        mem_wb_RegWrite,
    output logic        mem_wb_MemtoReg,
    output logic        misaligned_fault
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [0:DEPTH_WORDS-1];
    logic [AW-1:0] word_idx;
    logic          is_byte;
    logic          is_half;
    logic          misaligned_addr;
    logic          access_fault;
    logic          do_write;
    logic [3:0]    byte_en;
    logic [31:0]   wdata;

    // Captured at the MEM/WB edge so the read data can be formatted afterwards.
    logic [31:0]   raw_word_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic          is_load_q;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;

    assign forward_ex_mem = alu_data;
    assign word_idx       = alu_data[AW+1:2];

    always_comb begin
        is_byte = (funct3 == 3'b000) || (funct3 == 3'b100);
        is_half = (funct3 == 3'b001) || (funct3 == 3'b101);
        if (is_byte) begin
            misaligned_addr = 1'b0;
        end else if (is_half) begin
            misaligned_addr = alu_data[0];
        end else begin
            misaligned_addr = |alu_data[1:0];
        end
        access_fault = (mem_read || mem_write) && misaligned_addr;
        do_write     = mem_write && !stall && !flush && !rst && !misaligned_addr;
    end

    // Store data is replicated across lanes; the byte enables pick the lane.
    always_comb begin
        if (is_byte) begin
            wdata   = {4{memory_data[7:0]}};
            byte_en = 4'b0001 << alu_data[1:0];
        end else if (is_half) begin
            wdata   = {2{memory_data[15:0]}};
            byte_en = alu_data[1] ? 4'b1100 : 4'b0011;
        end else begin
            wdata   = memory_data;
            byte_en = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wb_alu_data  <= '0;
            mem_wb_rd        <= '0;
            mem_wb_RegWrite  <= 1'b0;
            mem_wb_MemtoReg  <= 1'b0;
            misaligned_fault <= 1'b0;
            is_load_q        <= 1'b0;
            raw_word_q       <= '0;
            f3_q             <= '0;
            off_q            <= '0;
        end else if (flush) begin
            mem_wb_alu_data  <= '0;
            mem_wb_rd        <= '0;
            mem_wb_RegWrite  <= 1'b0;
            mem_wb_MemtoReg  <= 1'b0;
            misaligned_fault <= 1'b0;
            is_load_q        <= 1'b0;
        end else if (!stall) begin
            mem_wb_alu_data  <= alu_data;
            mem_wb_rd        <= rd_in;
            mem_wb_RegWrite  <= reg_write_in && !access_fault;
            mem_wb_MemtoReg  <= mem_to_reg_in;
            misaligned_fault <= access_fault;
            is_load_q        <= mem_read;
            raw_word_q       <= mem[word_idx];
            f3_q             <= funct3;
            off_q            <= alu_data[1:0];
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    sel_byte = raw_word_q[7:0];
            2'd1:    sel_byte = raw_word_q[15:8];
            2'd2:    sel_byte = raw_word_q[23:16];
            default: sel_byte = raw_word_q[31:24];
        endcase
        sel_half = off_q[1] ? raw_word_q[31:16] : raw_word_q[15:0];
        case (f3_q)
            3'b000:  mem_wb_read_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  mem_wb_read_data = {24'h0, sel_byte};
            3'b001:  mem_wb_read_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  mem_wb_read_data = {16'h0, sel_half};
            default: mem_wb_read_data = raw_word_q;
        endcase
        if (!is_load_q) begin
            mem_wb_read_data = '0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, sized loads, faults, stall/flush, wrap-around and reset.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [2:0]  funct3;
    logic [31:0] alu_data;
    logic [31:0] memory_data;
    logic [4:0]  rd_in;
    logic [31:0] forward_ex_mem;
    logic [31:0] mem_wb_alu_data;
    logic [31:0] mem_wb_read_data;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_RegWrite;
    logic        mem_wb_MemtoReg;
    logic        misaligned_fault;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    mem_stage #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .funct3(funct3), .alu_data(alu_data), .memory_data(memory_data), .rd_in(rd_in),
        .forward_ex_mem(forward_ex_mem), .mem_wb_alu_data(mem_wb_alu_data),
        .mem_wb_read_data(mem_wb_read_data), .mem_wb_rd(mem_wb_rd),
        .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_MemtoReg(mem_wb_MemtoReg),
        .misaligned_fault(misaligned_fault)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic mr, input logic mw, input logic rw, input logic m2r,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd);
        mem_read = mr; mem_write = mw; reg_write_in = rw; mem_to_reg_in = m2r;
        funct3 = f3; alu_data = addr; memory_data = data; rd_in = rd;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic sw(input logic [31:0] addr, input logic [31:0] data);
        drive(0, 1, 0, 0, F_W, addr, data, 5'd0);
        step();
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        drive(1, 0, 1, 1, f3, addr, 32'h0, rd);
        step();
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(0, 1, 1, 1, F_W, 32'h44, 32'h12345678, 5'd3);
        step();
        step();
        checks++;
        if ({mem_wb_alu_data, mem_wb_read_data, mem_wb_rd, mem_wb_RegWrite, mem_wb_MemtoReg, misaligned_fault} !== 72'h0) begin
            errors++;
            $display("FAIL reset_outputs: got alu=%h rd_data=%h rd=%0d rw=%b m2r=%b flt=%b, want all 0",
                     mem_wb_alu_data, mem_wb_read_data, mem_wb_rd, mem_wb_RegWrite, mem_wb_MemtoReg, misaligned_fault);
        end
        drive(0, 0, 0, 0, F_W, 32'h89ABCDEF, 32'h0, 5'd0);
        #1;
        checks++;
        if (forward_ex_mem !== 32'h89ABCDEF) begin
            errors++;
            $display("FAIL forward_comb: got %h want 89abcdef", forward_ex_mem);
        end
        rst = 1'b0;
    endtask

    task automatic test_sw_lw;
        sw(32'h10, 32'hDEADBEEF);
        checks++;
        if ({mem_wb_read_data, mem_wb_RegWrite, misaligned_fault} !== 34'h0) begin
            errors++;
            $display("FAIL store_slot: got rd_data=%h rw=%b flt=%b want 0/0/0", mem_wb_read_data, mem_wb_RegWrite, misaligned_fault);
        end
        ld(F_W, 32'h10, 5'd5);
        checks++;
        if ({mem_wb_read_data, mem_wb_alu_data, mem_wb_rd, mem_wb_RegWrite, mem_wb_MemtoReg, misaligned_fault}
            !== {32'hDEADBEEF, 32'h10, 5'd5, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sw_lw: got rd_data=%h alu=%h rd=%0d rw=%b m2r=%b flt=%b want deadbeef/10/5/1/1/0",
                     mem_wb_read_data, mem_wb_alu_data, mem_wb_rd, mem_wb_RegWrite, mem_wb_MemtoReg, misaligned_fault);
        end
        drive(0, 0, 1, 0, F_W, 32'h1234, 32'h0, 5'd6);
        step();
        checks++;
        if ({mem_wb_read_data, mem_wb_alu_data, mem_wb_RegWrite} !== {32'h0, 32'h1234, 1'b1}) begin
            errors++;
            $display("FAIL alu_op: got rd_data=%h alu=%h rw=%b want 0/1234/1", mem_wb_read_data, mem_wb_alu_data, mem_wb_RegWrite);
        end
    endtask

    task automatic test_byte_half;
        drive(0, 1, 0, 0, F_B, 32'h13, 32'h12345680, 5'd0);
        step();
        ld(F_B, 32'h13, 5'd1);
        checks++;
        if (mem_wb_read_data !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb_13: got %h want ffffff80", mem_wb_read_data);
        end
        ld(F_BU, 32'h13, 5'd1);
        checks++;
        if (mem_wb_read_data !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu_13: got %h want 00000080", mem_wb_read_data);
        end
        ld(F_W, 32'h10, 5'd1);
        checks++;
        if (mem_wb_read_data !== 32'h80ADBEEF) begin
            errors++;
            $display("FAIL sb_neighbours: got %h want 80adbeef", mem_wb_read_data);
        end
        ld(F_B, 32'h10, 5'd1);
        checks++;
        if (mem_wb_read_data !== 32'hFFFFFFEF) begin
            errors++;
            $display("FAIL lb_10: got %h want ffffffef", mem_wb_read_data);
        end
        ld(F_BU, 32'h11, 5'd1);
        checks++;
        if (mem_wb_read_data !== 32'h000000BE) begin
            errors++;
            $display("FAIL lbu_11: got %h want 000000be", mem_wb_read_data);
        end
        ld(F_H, 32'h12, 5'd1);
        checks++;
        if (mem_wb_read_data !== 32'hFFFF80AD) begin
            errors++;
            $display("FAIL lh_12: got %h want ffff80ad", mem_wb_read_data);
        end
        ld(F_HU, 32'h10, 5'd1);
        checks++;
        if (mem_wb_read_data !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL lhu_10: got %h want 0000beef", mem_wb_read_data);
        end
        sw(32'h50, 32'hA5A5A5A5);
        drive(0, 1, 0, 0, F_H, 32'h52, 32'h00017FFF, 5'd0);
        step();
        ld(F_W, 32'h50, 5'd2);
        checks++;
        if (mem_wb_read_data !== 32'h7FFFA5A5) begin
            errors++;
            $display("FAIL sh_52: got %h want 7fffa5a5", mem_wb_read_data);
        end
        ld(F_H, 32'h50, 5'd2);
        checks++;
        if (mem_wb_read_data !== 32'hFFFFA5A5) begin
            errors++;
            $display("FAIL lh_50: got %h want ffffa5a5", mem_wb_read_data);
        end
    endtask

    task automatic test_misaligned;
        ld(F_H, 32'h11, 5'd4);
        checks++;
        if ({misaligned_fault, mem_wb_RegWrite} !== 2'b10) begin
            errors++;
            $display("FAIL lh_11_fault: got flt=%b rw=%b want 1/0", misaligned_fault, mem_wb_RegWrite);
        end
        sw(32'h20, 32'h11223344);
        sw(32'h22, 32'hFFFFFFFF);
        checks++;
        if (misaligned_fault !== 1'b1) begin
            errors++;
            $display("FAIL sw_22_fault: got %b want 1", misaligned_fault);
        end
        ld(F_W, 32'h20, 5'd4);
        checks++;
        if ({mem_wb_read_data, misaligned_fault, mem_wb_RegWrite} !== {32'h11223344, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sw_22_suppressed: got %h flt=%b rw=%b want 11223344/0/1", mem_wb_read_data, misaligned_fault, mem_wb_RegWrite);
        end
        ld(F_BU, 32'h21, 5'd4);
        checks++;
        if ({mem_wb_read_data, misaligned_fault} !== {32'h00000033, 1'b0}) begin
            errors++;
            $display("FAIL lbu_21: got %h flt=%b want 00000033/0", mem_wb_read_data, misaligned_fault);
        end
        drive(0, 1, 0, 0, 3'b011, 32'h30, 32'h01020304, 5'd0);
        step();
        ld(3'b111, 32'h30, 5'd4);
        checks++;
        if (mem_wb_read_data !== 32'h01020304) begin
            errors++;
            $display("FAIL funct3_other_word: got %h want 01020304", mem_wb_read_data);
        end
        ld(3'b110, 32'h32, 5'd4);
        checks++;
        if (misaligned_fault !== 1'b1) begin
            errors++;
            $display("FAIL funct3_other_fault: got %b want 1", misaligned_fault);
        end
    endtask

    task automatic test_stall_flush;
        ld(F_W, 32'h10, 5'd7);
        stall = 1'b1;
        drive(0, 1, 1, 0, F_W, 32'h10, 32'h0, 5'd12);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({mem_wb_alu_data, mem_wb_read_data, mem_wb_rd, mem_wb_RegWrite, mem_wb_MemtoReg, misaligned_fault}
                !== {32'h10, 32'h80ADBEEF, 5'd7, 1'b1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got alu=%h rd_data=%h rd=%0d rw=%b m2r=%b flt=%b want 10/80adbeef/7/1/1/0",
                         i, mem_wb_alu_data, mem_wb_read_data, mem_wb_rd, mem_wb_RegWrite, mem_wb_MemtoReg, misaligned_fault);
            end
        end
        flush = 1'b1;
        drive(1, 0, 1, 1, F_H, 32'h11, 32'h0, 5'd4);
        step();
        checks++;
        if ({mem_wb_read_data, mem_wb_rd, mem_wb_RegWrite, mem_wb_MemtoReg, misaligned_fault} !== 40'h0) begin
            errors++;
            $display("FAIL flush_bubble: got rd_data=%h rd=%0d rw=%b m2r=%b flt=%b want all 0",
                     mem_wb_read_data, mem_wb_rd, mem_wb_RegWrite, mem_wb_MemtoReg, misaligned_fault);
        end
        stall = 1'b0;
        sw(32'h10, 32'h0);
        flush = 1'b0;
        ld(F_W, 32'h10, 5'd7);
        checks++;
        if (mem_wb_read_data !== 32'h80ADBEEF) begin
            errors++;
            $display("FAIL stall_flush_no_write: got %h want 80adbeef", mem_wb_read_data);
        end
    endtask

    task automatic test_wrap;
        sw(32'h400, 32'hCAFEF00D);
        ld(F_W, 32'h000, 5'd8);
        checks++;
        if (mem_wb_read_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wrap_400: got %h want cafef00d", mem_wb_read_data);
        end
    endtask

    task automatic test_reset_store;
        sw(32'h40, 32'hAAAA5555);
        ld(F_W, 32'h10, 5'd9);
        rst = 1'b1;
        drive(0, 1, 1, 1, F_W, 32'h40, 32'h12345678, 5'd9);
        step();
        rst = 1'b0;
        checks++;
        if ({mem_wb_alu_data, mem_wb_read_data, mem_wb_rd, mem_wb_RegWrite, mem_wb_MemtoReg, misaligned_fault} !== 72'h0) begin
            errors++;
            $display("FAIL reset_sw_outputs: got alu=%h rd_data=%h rd=%0d rw=%b m2r=%b flt=%b want all 0",
                     mem_wb_alu_data, mem_wb_read_data, mem_wb_rd, mem_wb_RegWrite, mem_wb_MemtoReg, misaligned_fault);
        end
        ld(F_W, 32'h40, 5'd9);
        checks++;
        if (mem_wb_read_data !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL reset_sw_mem: got %h want aaaa5555", mem_wb_read_data);
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_byte_half();
        test_misaligned();
        test_stall_flush();
        test_wrap();
        test_reset_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
